// File: rtl/rom_sprite_render.sv
// ROM sprite renderer: composites one scaled/mirrored/colour-keyed ROM picture
// over a ten-bar background, with sprite parameters latched once per frame.
module rom_sprite_render #(
   parameter int unsigned H_VALID   = 640,
   parameter int unsigned V_VALID   = 480,
   parameter int unsigned PIC_W     = 100,
   parameter int unsigned PIC_H     = 100,
   parameter int unsigned ADDR_W    = 14,
   parameter bit          KEY_EN    = 1'b1,
   parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic [1:0]        scale,
   input  logic              mirror_x,
   input  logic              mirror_y,
   input  logic              spr_en,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd_en,
   input  logic [15:0]       rom_data,
   output logic [15:0]       pix_data_out,
   output logic              sprite_hit,
   output logic              frame_tick
);

   localparam int unsigned CW    = 11;
   localparam int unsigned EW    = 13;
   localparam int unsigned BAR_W = H_VALID / 10;

   logic [9:0]        sx_q, sy_q;
   logic [1:0]        sh_q, sh_d;
   logic              mx_q, my_q, en_q;
   logic              tick_q;
   logic              cap;
   logic [CW-1:0]     px, py, rx, ry, col, row;
   logic [EW-1:0]     spr_w, spr_h;
   logic              in_spr;
   logic [ADDR_W-1:0] col_m, row_m;
   logic [3:0]        bar;
   logic [15:0]       bar_color, bg_d;
   logic              in_spr_q;
   logic [15:0]       bg_q;
   logic              keyed;
   logic [15:0]       pix_q;
   logic              hit_q;

   assign cap = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));

   always_comb begin
      sh_d = 2'd0;
      case (scale)
         2'd1:    sh_d = 2'd1;
         2'd2:    sh_d = 2'd2;
         default: sh_d = 2'd0;
      endcase
   end

   // Shadow registers load only on the last visible pixel so the sprite never tears.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sx_q   <= '0;
         sy_q   <= '0;
         sh_q   <= '0;
         mx_q   <= 1'b0;
         my_q   <= 1'b0;
         en_q   <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= cap;
         if (cap) begin
            sx_q <= pos_x;
            sy_q <= pos_y;
            sh_q <= sh_d;
            mx_q <= mirror_x;
            my_q <= mirror_y;
            en_q <= spr_en;
         end
      end
   end

   always_comb begin
      px     = {1'b0, pix_x};
      py     = {1'b0, pix_y};
      rx     = px - {1'b0, sx_q};
      ry     = py - {1'b0, sy_q};
      spr_w  = EW'(PIC_W) << sh_q;
      spr_h  = EW'(PIC_H) << sh_q;
      in_spr = en_q
               && (pix_x >= sx_q) && ({2'b00, rx} < spr_w)
               && (pix_y >= sy_q) && ({2'b00, ry} < spr_h)
               && (px < CW'(H_VALID)) && (py < CW'(V_VALID));
      col    = rx >> sh_q;
      row    = ry >> sh_q;
      col_m  = mx_q ? (ADDR_W'(PIC_W - 1) - ADDR_W'(col)) : ADDR_W'(col);
      row_m  = my_q ? (ADDR_W'(PIC_H - 1) - ADDR_W'(row)) : ADDR_W'(row);
   end

   assign rom_addr  = in_spr ? (row_m * ADDR_W'(PIC_W) + col_m) : '0;
   assign rom_rd_en = in_spr;

   // Bar index by threshold compare rather than a divider.
   always_comb begin
      bar = 4'd0;
      for (int unsigned i = 1; i < 10; i++) begin
         if (px >= CW'(i * BAR_W)) bar = 4'(i);
      end
   end

   always_comb begin
      bar_color = 16'h0000;
      case (bar)
         4'd0:    bar_color = 16'hF800;
         4'd1:    bar_color = 16'hFC00;
         4'd2:    bar_color = 16'hFFE0;
         4'd3:    bar_color = 16'h07E0;
         4'd4:    bar_color = 16'h07FF;
         4'd5:    bar_color = 16'h001F;
         4'd6:    bar_color = 16'hF81F;
         4'd7:    bar_color = 16'h0000;
         4'd8:    bar_color = 16'hFFFF;
         4'd9:    bar_color = 16'hD69A;
         default: bar_color = 16'h0000;
      endcase
      bg_d = ((px < CW'(H_VALID)) && (py < CW'(V_VALID))) ? bar_color : 16'h0000;
   end

   assign keyed = KEY_EN && (rom_data == KEY_COLOR);

   // Stage 1 aligns hit/background with the registered ROM; stage 2 composites.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         in_spr_q <= 1'b0;
         bg_q     <= '0;
         pix_q    <= '0;
         hit_q    <= 1'b0;
      end else begin
         in_spr_q <= in_spr;
         bg_q     <= bg_d;
         if (in_spr_q && !keyed) begin
            pix_q <= rom_data;
            hit_q <= 1'b1;
         end else begin
            pix_q <= bg_q;
            hit_q <= 1'b0;
         end
      end
   end

   assign pix_data_out = pix_q;
   assign sprite_hit   = hit_q;
   assign frame_tick   = tick_q;

endmodule

// File: tb/tb_rom_sprite_render.sv
// Randomised bench for rom_sprite_render against a frame-level reference model,
// with a keyed and an unkeyed instance sharing the same stimulus and ROM image.
module tb_rom_sprite_render;

   localparam logic [15:0] KEY = 16'hF81F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  pix_x, pix_y, pos_x, pos_y;
   logic [1:0]  scale;
   logic        mirror_x, mirror_y, spr_en;
   logic [13:0] addr_a, addr_b;
   logic        rd_a, rd_b;
   logic [15:0] q_a, q_b, out_a, out_b;
   logic        hit_a, hit_b, tick_a, tick_b;

   logic [15:0] mem [10000];
   logic [15:0] bar_col [10] = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
                                 16'h001F, 16'hF81F, 16'h0000, 16'hFFFF, 16'hD69A};

   int n_chk  = 0;
   int n_pass = 0;

   int m_px, m_py, m_scale;
   bit m_mx, m_my, m_en;

   bit          pend;
   logic [15:0] pend_a, pend_b;
   bit          pend_ha, pend_hb;

   always #20 clk = ~clk;

   always @(posedge clk) begin
      q_a <= (addr_a < 14'd10000) ? mem[addr_a] : 16'h0000;
      q_b <= (addr_b < 14'd10000) ? mem[addr_b] : 16'h0000;
   end

   rom_sprite_render u_dut (
      .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
      .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .mirror_x(mirror_x),
      .mirror_y(mirror_y), .spr_en(spr_en), .rom_addr(addr_a), .rom_rd_en(rd_a),
      .rom_data(q_a), .pix_data_out(out_a), .sprite_hit(hit_a), .frame_tick(tick_a)
   );

   rom_sprite_render #(.KEY_EN(1'b0)) u_dut_nokey (
      .vga_clk(clk), .sys_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
      .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .mirror_x(mirror_x),
      .mirror_y(mirror_y), .spr_en(spr_en), .rom_addr(addr_b), .rom_rd_en(rd_b),
      .rom_data(q_b), .pix_data_out(out_b), .sprite_hit(hit_b), .frame_tick(tick_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Frame-level view: sprite occupies a PIC*k square at the latched position.
   function automatic void ref_pixel(input int x, input int y, output bit hit, output int addr);
      int k, rx, ry, c, r;
      k    = (m_scale == 1) ? 2 : ((m_scale == 2) ? 4 : 1);
      rx   = x - m_px;
      ry   = y - m_py;
      hit  = m_en && (x < 640) && (y < 480) && (rx >= 0) && (ry >= 0)
             && (rx < 100 * k) && (ry < 100 * k);
      addr = 0;
      if (hit) begin
         c = rx / k;
         r = ry / k;
         if (m_mx) c = 99 - c;
         if (m_my) r = 99 - r;
         addr = r * 100 + c;
      end
   endfunction

   function automatic logic [15:0] ref_bg(input int x, input int y);
      if (x >= 640 || y >= 480) return 16'h0000;
      return bar_col[x / 64];
   endfunction

   task automatic step(input int x, input int y);
      bit          hit, cap;
      int          addr;
      logic [15:0] w, bg, ea, eb;
      bit          eha, ehb;
      pix_x = 10'(x);
      pix_y = 10'(y);
      #1;
      ref_pixel(x, y, hit, addr);
      check("rd_en", rd_a, hit);
      check("rom_addr", addr_a, addr);
      check("rd_en_nokey", rd_b, hit);
      bg  = ref_bg(x, y);
      w   = hit ? mem[addr] : 16'h0000;
      eha = hit && (w != KEY);
      ea  = eha ? w : bg;
      ehb = hit;
      eb  = hit ? w : bg;
      cap = (x == 639) && (y == 479);
      @(posedge clk);
      #1;
      if (cap) begin
         m_px    = pos_x;
         m_py    = pos_y;
         m_scale = scale;
         m_mx    = mirror_x;
         m_my    = mirror_y;
         m_en    = spr_en;
      end
      check("frame_tick", tick_a, cap);
      if (pend) begin
         check("pix_out", out_a, pend_a);
         check("sprite_hit", hit_a, pend_ha);
         check("pix_out_nokey", out_b, pend_b);
         check("sprite_hit_nokey", hit_b, pend_hb);
      end
      pend    = 1'b1;
      pend_a  = ea;
      pend_ha = eha;
      pend_b  = eb;
      pend_hb = ehb;
   endtask

   task automatic capture(input int px, input int py, input int sc, input bit mx, input bit my,
                          input bit en);
      pos_x    = 10'(px);
      pos_y    = 10'(py);
      scale    = 2'(sc);
      mirror_x = mx;
      mirror_y = my;
      spr_en   = en;
      step(639, 479);
   endtask

   task automatic model_reset();
      m_px = 0; m_py = 0; m_scale = 0; m_mx = 0; m_my = 0; m_en = 0;
      pend = 1'b0;
   endtask

   initial begin
      int x, y;
      for (int i = 0; i < 10000; i++)
         mem[i] = ($urandom_range(0, 7) == 0) ? KEY : 16'($urandom);
      mem[5] = KEY;
      mem[0] = 16'h1234;
      model_reset();
      rst_n = 1'b0;
      pix_x = '0; pix_y = '0; pos_x = '0; pos_y = '0;
      scale = '0; mirror_x = 1'b0; mirror_y = 1'b0; spr_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pix", out_a, 16'h0);
      check("rst_hit", hit_a, 1'b0);
      check("rst_tick", tick_a, 1'b0);
      check("rst_rd_en", rd_a, 1'b0);
      check("rst_addr", addr_a, 14'h0);
      rst_n = 1'b1;

      // No sprite before the first capture even though enable is requested.
      spr_en = 1'b1; pos_x = 10'd0; pos_y = 10'd0;
      step(0, 0);
      step(10, 10);

      capture(270, 190, 0, 0, 0, 1);
      step(270, 190); step(369, 190); step(270, 191); step(369, 289);
      step(370, 190); step(269, 190); step(270, 290);

      capture(0, 0, 1, 0, 0, 1);
      step(0, 0); step(1, 0); step(0, 1); step(1, 1); step(2, 0); step(0, 2);
      step(199, 199); step(200, 0); step(0, 200); step(5, 0);

      capture(0, 0, 2, 0, 0, 1);
      step(399, 399); step(400, 0); step(3, 3); step(4, 4);

      capture(0, 0, 0, 1, 1, 1);
      step(0, 0); step(99, 99); step(50, 20);

      capture(0, 0, 3, 0, 0, 1);
      step(5, 0); step(99, 0); step(100, 0); step(0, 99);

      capture(600, 430, 0, 0, 0, 1);
      step(600, 430); step(639, 430); step(640, 430); step(700, 450);
      step(599, 430); step(620, 479); step(620, 480);
      // Pending position changes stay invisible until the next capture.
      pos_x = 10'd0; pos_y = 10'd0;
      step(600, 430); step(0, 0);
      // Capture pixel is itself a sprite pixel: still drawn with the old shadows.
      capture(0, 0, 0, 0, 0, 1);
      step(0, 0); step(600, 430);

      capture(639, 10, 0, 0, 0, 1);
      step(639, 10); step(638, 10); step(639, 109); step(640, 10);
      capture(700, 10, 0, 0, 0, 1);
      step(700, 10); step(639, 10); step(800, 50);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            capture($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), $urandom_range(0, 4) != 0);
         end else if ($urandom_range(0, 1) == 0) begin
            x = m_px + $urandom_range(0, 420) - 10;
            y = m_py + $urandom_range(0, 420) - 10;
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            step(x % 1024, y % 1024);
         end else begin
            step($urandom_range(0, 700), $urandom_range(0, 520));
         end
      end

      // Reset pulse in the middle of a drawn sprite.
      capture(100, 100, 0, 0, 0, 1);
      step(150, 150);
      step(151, 150);
      pix_x = 10'd152; pix_y = 10'd150;
      #5;
      rst_n = 1'b0;
      #1;
      check("midrst_pix", out_a, 16'h0);
      check("midrst_hit", hit_a, 1'b0);
      check("midrst_rd_en", rd_a, 1'b0);
      check("midrst_tick", tick_a, 1'b0);
      check("midrst_hit_nokey", hit_b, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(152, 150); step(153, 150); step(100, 100);
      capture(100, 100, 0, 0, 0, 1);
      step(152, 150); step(100, 100); step(199, 199);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
